// File: rtl/riscv_instr_decoder.sv
// riscv_instr_decoder
//
// Disassembly helper for one 32-bit RV64IM instruction word. Produces the
// mnemonic, the ABI names of the registers involved, the decoded immediate
// and a flag word describing how the operands should be printed. Decode is
// purely combinational; the only state is a sticky "illegal word seen" bit.
//
// Ports:
//   clk              in   clock (only used by illegal_seen)
//   reset            in   synchronous, active-high; clears illegal_seen
//   instruction      in   32-bit instruction word
//   rd, rs1, rs2     out  ABI register names, ASCII, right-justified, 0 if unused
//   imm              out  sign-extended immediate (shamt for shift-immediates)
//   flag             out  operand-format descriptor:
//                           [0] rd valid  [1] rs1 valid  [2] rs2 valid  [3] imm valid
//                           [6:4] format R=0 I=1 S=2 B=3 U=4 J=5
//                           [7] imm(rs1) memory form  [8] illegal
//                           [9] shift-immediate  [10] no printed operands
//   instruction_name out  mnemonic, ASCII, right-justified
//   illegal_seen     out  sticky: an undecodable word was present at a clock edge
//
// String fields carry one spare top bit beyond the character storage; it is
// always zero.

module riscv_instr_decoder #(
    parameter int REGISTER_NAME_WIDTH    = 4,
    parameter int IMMEDIATE_WIDTH        = 32,
    parameter int FLAG_WIDTH             = 16,
    parameter int INSTRUCTION_NAME_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [31:0]                         instruction,
    output logic [REGISTER_NAME_WIDTH*8:0]      rd,
    output logic [REGISTER_NAME_WIDTH*8:0]      rs1,
    output logic [REGISTER_NAME_WIDTH*8:0]      rs2,
    output logic signed [IMMEDIATE_WIDTH-1:0]   imm,
    output logic [FLAG_WIDTH-1:0]               flag,
    output logic [INSTRUCTION_NAME_WIDTH*8:0]   instruction_name,
    output logic                                illegal_seen
);

    localparam int RB = REGISTER_NAME_WIDTH * 8;
    localparam int NB = INSTRUCTION_NAME_WIDTH * 8;
    localparam int IW = IMMEDIATE_WIDTH;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_idx;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;

    assign opcode  = instruction[6:0];
    assign rd_idx  = instruction[11:7];
    assign funct3  = instruction[14:12];
    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];
    assign funct7  = instruction[31:25];

    function automatic logic [RB-1:0] reg_name(input logic [4:0] idx);
        logic [RB-1:0] s;
        s = '0;
        case (idx)
            5'd0:  s = RB'("zero");
            5'd1:  s = RB'("ra");
            5'd2:  s = RB'("sp");
            5'd3:  s = RB'("gp");
            5'd4:  s = RB'("tp");
            5'd5:  s = RB'("t0");
            5'd6:  s = RB'("t1");
            5'd7:  s = RB'("t2");
            5'd8:  s = RB'("s0");
            5'd9:  s = RB'("s1");
            5'd10: s = RB'("a0");
            5'd11: s = RB'("a1");
            5'd12: s = RB'("a2");
            5'd13: s = RB'("a3");
            5'd14: s = RB'("a4");
            5'd15: s = RB'("a5");
            5'd16: s = RB'("a6");
            5'd17: s = RB'("a7");
            5'd18: s = RB'("s2");
            5'd19: s = RB'("s3");
            5'd20: s = RB'("s4");
            5'd21: s = RB'("s5");
            5'd22: s = RB'("s6");
            5'd23: s = RB'("s7");
            5'd24: s = RB'("s8");
            5'd25: s = RB'("s9");
            5'd26: s = RB'("s10");
            5'd27: s = RB'("s11");
            5'd28: s = RB'("t3");
            5'd29: s = RB'("t4");
            5'd30: s = RB'("t5");
            5'd31: s = RB'("t6");
            default: s = '0;
        endcase
        return s;
    endfunction

    // Decode results before the final illegal override.
    logic [NB-1:0] name;
    logic [2:0]    fmt;
    logic          illegal;
    logic          mem_form;
    logic          shift_form;
    logic          no_ops;
    logic          use_rd;
    logic          use_rs1;
    logic          use_rs2;
    logic          use_imm;
    logic [IW-1:0] imm_val;

    // Mnemonic and format selection; full opcode/funct3/funct7 match.
    always_comb begin
        name       = '0;
        fmt        = FMT_R;
        illegal    = 1'b0;
        mem_form   = 1'b0;
        shift_form = 1'b0;
        no_ops     = 1'b0;
        case (opcode)
            7'b0110111: begin name = NB'("lui");   fmt = FMT_U; end
            7'b0010111: begin name = NB'("auipc"); fmt = FMT_U; end
            7'b1101111: begin name = NB'("jal");   fmt = FMT_J; end
            7'b1100111: begin
                fmt = FMT_I;
                if (funct3 == 3'b000) name = NB'("jalr");
                else                  illegal = 1'b1;
            end
            7'b1100011: begin
                fmt = FMT_B;
                case (funct3)
                    3'b000:  name = NB'("beq");
                    3'b001:  name = NB'("bne");
                    3'b100:  name = NB'("blt");
                    3'b101:  name = NB'("bge");
                    3'b110:  name = NB'("bltu");
                    3'b111:  name = NB'("bgeu");
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                fmt      = FMT_I;
                mem_form = 1'b1;
                case (funct3)
                    3'b000:  name = NB'("lb");
                    3'b001:  name = NB'("lh");
                    3'b010:  name = NB'("lw");
                    3'b011:  name = NB'("ld");
                    3'b100:  name = NB'("lbu");
                    3'b101:  name = NB'("lhu");
                    3'b110:  name = NB'("lwu");
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                fmt      = FMT_S;
                mem_form = 1'b1;
                case (funct3)
                    3'b000:  name = NB'("sb");
                    3'b001:  name = NB'("sh");
                    3'b010:  name = NB'("sw");
                    3'b011:  name = NB'("sd");
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000: name = NB'("addi");
                    3'b010: name = NB'("slti");
                    3'b011: name = NB'("sltiu");
                    3'b100: name = NB'("xori");
                    3'b110: name = NB'("ori");
                    3'b111: name = NB'("andi");
                    // RV64 shifts: funct6 in [31:26], 6-bit shamt in [25:20].
                    3'b001: begin
                        shift_form = 1'b1;
                        if (funct7[6:1] == 6'b000000) name = NB'("slli");
                        else                          illegal = 1'b1;
                    end
                    default: begin
                        shift_form = 1'b1;
                        if (funct7[6:1] == 6'b000000)      name = NB'("srli");
                        else if (funct7[6:1] == 6'b010000) name = NB'("srai");
                        else                               illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                fmt = FMT_R;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  name = NB'("add");
                            3'b001:  name = NB'("sll");
                            3'b010:  name = NB'("slt");
                            3'b011:  name = NB'("sltu");
                            3'b100:  name = NB'("xor");
                            3'b101:  name = NB'("srl");
                            3'b110:  name = NB'("or");
                            default: name = NB'("and");
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      name = NB'("sub");
                        else if (funct3 == 3'b101) name = NB'("sra");
                        else                       illegal = 1'b1;
                    end
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  name = NB'("mul");
                            3'b001:  name = NB'("mulh");
                            3'b010:  name = NB'("mulhsu");
                            3'b011:  name = NB'("mulhu");
                            3'b100:  name = NB'("div");
                            3'b101:  name = NB'("divu");
                            3'b110:  name = NB'("rem");
                            default: name = NB'("remu");
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0011011: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000: name = NB'("addiw");
                    // Word shifts: 5-bit shamt, full funct7 must match.
                    3'b001: begin
                        shift_form = 1'b1;
                        if (funct7 == 7'b0000000) name = NB'("slliw");
                        else                      illegal = 1'b1;
                    end
                    3'b101: begin
                        shift_form = 1'b1;
                        if (funct7 == 7'b0000000)      name = NB'("srliw");
                        else if (funct7 == 7'b0100000) name = NB'("sraiw");
                        else                           illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0111011: begin
                fmt = FMT_R;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: name = NB'("addw");
                    {7'b0000000, 3'b001}: name = NB'("sllw");
                    {7'b0000000, 3'b101}: name = NB'("srlw");
                    {7'b0100000, 3'b000}: name = NB'("subw");
                    {7'b0100000, 3'b101}: name = NB'("sraw");
                    {7'b0000001, 3'b000}: name = NB'("mulw");
                    {7'b0000001, 3'b100}: name = NB'("divw");
                    {7'b0000001, 3'b101}: name = NB'("divuw");
                    {7'b0000001, 3'b110}: name = NB'("remw");
                    {7'b0000001, 3'b111}: name = NB'("remuw");
                    default:              illegal = 1'b1;
                endcase
            end
            7'b0001111: begin
                fmt    = FMT_I;
                no_ops = 1'b1;
                if (funct3 == 3'b000) name = NB'("fence");
                else                  illegal = 1'b1;
            end
            7'b1110011: begin
                fmt    = FMT_I;
                no_ops = 1'b1;
                if (instruction == 32'h0000_0073)      name = NB'("ecall");
                else if (instruction == 32'h0010_0073) name = NB'("ebreak");
                else                                   illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Operand presence and immediate follow from the format.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_imm = 1'b0;
        imm_val = '0;
        case (fmt)
            FMT_R: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            FMT_I: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_imm = 1'b1;
                if (shift_form && opcode == 7'b0010011)
                    imm_val = IW'(instruction[25:20]);
                else if (shift_form)
                    imm_val = IW'(instruction[24:20]);
                else
                    imm_val = IW'($signed(instruction[31:20]));
            end
            FMT_S: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1;
                imm_val = IW'($signed({instruction[31:25], instruction[11:7]}));
            end
            FMT_B: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1;
                imm_val = IW'($signed({instruction[31], instruction[7],
                                       instruction[30:25], instruction[11:8], 1'b0}));
            end
            FMT_U: begin
                use_rd = 1'b1; use_imm = 1'b1;
                imm_val = IW'($signed(instruction[31:12]));
            end
            FMT_J: begin
                use_rd = 1'b1; use_imm = 1'b1;
                imm_val = IW'($signed({instruction[31], instruction[19:12],
                                       instruction[20], instruction[30:21], 1'b0}));
            end
            default: begin
                use_rd = 1'b0;
            end
        endcase
        // fence/ecall/ebreak print nothing, so every operand field is blanked.
        if (no_ops || illegal) begin
            use_rd  = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_imm = 1'b0;
            imm_val = '0;
        end
    end

    // Output assembly; illegal words collapse to the fixed "illegal" record.
    always_comb begin
        rd               = use_rd  ? {1'b0, reg_name(rd_idx)}  : '0;
        rs1              = use_rs1 ? {1'b0, reg_name(rs1_idx)} : '0;
        rs2              = use_rs2 ? {1'b0, reg_name(rs2_idx)} : '0;
        imm              = imm_val;
        flag             = '0;
        instruction_name = {1'b0, name};
        if (illegal) begin
            flag[8]          = 1'b1;
            instruction_name = {1'b0, NB'("illegal")};
        end else begin
            flag[0]   = use_rd;
            flag[1]   = use_rs1;
            flag[2]   = use_rs2;
            flag[3]   = use_imm;
            flag[6:4] = fmt;
            flag[7]   = mem_form;
            flag[9]   = shift_form;
            flag[10]  = no_ops;
        end
    end

    // Sticky illegal indicator; reset wins over a coincident illegal word.
    always_ff @(posedge clk) begin
        if (reset)
            illegal_seen <= 1'b0;
        else if (illegal)
            illegal_seen <= 1'b1;
    end

endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Directed testbench for riscv_instr_decoder: a table of instruction words
// with hand-computed disassembly, followed by a clocked sequence exercising
// the sticky illegal_seen bit and its reset priority.

module tb_riscv_instr_decoder;

    logic          clk;
    logic          reset;
    logic [31:0]   instruction;
    logic [32:0]   rd;
    logic [32:0]   rs1;
    logic [32:0]   rs2;
    logic signed [31:0] imm;
    logic [15:0]   flag;
    logic [96:0]   instruction_name;
    logic          illegal_seen;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_instr_decoder dut (
        .clk              (clk),
        .reset            (reset),
        .instruction      (instruction),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm              (imm),
        .flag             (flag),
        .instruction_name (instruction_name),
        .illegal_seen     (illegal_seen)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [95:0] name;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [15:0] flag;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input int i);
        check($sformatf("v%0d name", i), 128'(instruction_name), 128'({1'b0, vecs[i].name}));
        check($sformatf("v%0d rd", i),   128'(rd),   128'({1'b0, vecs[i].rd}));
        check($sformatf("v%0d rs1", i),  128'(rs1),  128'({1'b0, vecs[i].rs1}));
        check($sformatf("v%0d rs2", i),  128'(rs2),  128'({1'b0, vecs[i].rs2}));
        check($sformatf("v%0d imm", i),  128'($unsigned(imm)), 128'(vecs[i].imm));
        check($sformatf("v%0d flag", i), 128'(flag), 128'(vecs[i].flag));
    endtask

    initial begin
        //               instr         name              rd            rs1           rs2           imm           flag
        vecs[0]  = '{32'h00000013, 96'("addi"),    32'("zero"), 32'("zero"), 32'h0,       32'h0,        16'h001B};
        vecs[1]  = '{32'hfe010113, 96'("addi"),    32'("sp"),   32'("sp"),   32'h0,       32'hffffffe0, 16'h001B};
        vecs[2]  = '{32'h00813423, 96'("sd"),      32'h0,       32'("sp"),   32'("s0"),   32'h8,        16'h00AE};
        vecs[3]  = '{32'h02b50533, 96'("mul"),     32'("a0"),   32'("a0"),   32'("a1"),   32'h0,        16'h0007};
        vecs[4]  = '{32'h008000ef, 96'("jal"),     32'("ra"),   32'h0,       32'h0,       32'h8,        16'h0059};
        vecs[5]  = '{32'h00000073, 96'("ecall"),   32'h0,       32'h0,       32'h0,       32'h0,        16'h0410};
        vecs[6]  = '{32'h00100073, 96'("ebreak"),  32'h0,       32'h0,       32'h0,       32'h0,        16'h0410};
        vecs[7]  = '{32'h00000000, 96'("illegal"), 32'h0,       32'h0,       32'h0,       32'h0,        16'h0100};
        vecs[8]  = '{32'h12345537, 96'("lui"),     32'("a0"),   32'h0,       32'h0,       32'h00012345, 16'h0049};
        vecs[9]  = '{32'hfffff0b7, 96'("lui"),     32'("ra"),   32'h0,       32'h0,       32'hffffffff, 16'h0049};
        vecs[10] = '{32'h43f55513, 96'("srai"),    32'("a0"),   32'("a0"),   32'h0,       32'd63,       16'h021B};
        vecs[11] = '{32'h41f5551b, 96'("sraiw"),   32'("a0"),   32'("a0"),   32'h0,       32'd31,       16'h021B};
        vecs[12] = '{32'h0205151b, 96'("illegal"), 32'h0,       32'h0,       32'h0,       32'h0,        16'h0100};
        vecs[13] = '{32'h20b50533, 96'("illegal"), 32'h0,       32'h0,       32'h0,       32'h0,        16'h0100};
        vecs[14] = '{32'hfe050ee3, 96'("beq"),     32'h0,       32'("a0"),   32'("zero"), 32'hfffffffc, 16'h003E};
        vecs[15] = '{32'h01043783, 96'("ld"),      32'("a5"),   32'("s0"),   32'h0,       32'd16,       16'h009B};
        vecs[16] = '{32'h00008067, 96'("jalr"),    32'("zero"), 32'("ra"),   32'h0,       32'h0,        16'h001B};
        vecs[17] = '{32'h03cdffbb, 96'("remuw"),   32'("t6"),   32'("s11"),  32'("t3"),   32'h0,        16'h0007};

        reset       = 1'b1;
        instruction = 32'h00000013;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_clears_sticky", 128'(illegal_seen), 128'(1'b0));
        // Decode is combinational and ignores reset.
        check("decode_during_reset", 128'(instruction_name), 128'({1'b0, 96'("addi")}));

        // Table-driven combinational checks (reset held so the sticky bit is untouched).
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            instruction = vecs[i].instr;
            #1;
            check_vec(i);
        end

        // Sticky sequence.
        @(negedge clk);
        instruction = 32'h00000013;
        reset       = 1'b0;
        @(negedge clk);
        check("legal_keeps_clear", 128'(illegal_seen), 128'(1'b0));
        instruction = 32'h00000000;
        #1;
        check("seq_illegal_name", 128'(instruction_name), 128'({1'b0, 96'("illegal")}));
        check("seq_illegal_flag", 128'(flag), 128'(16'h0100));
        check("sticky_before_edge", 128'(illegal_seen), 128'(1'b0));
        @(negedge clk);
        check("sticky_set", 128'(illegal_seen), 128'(1'b1));
        instruction = 32'h00000013;
        @(negedge clk);
        check("sticky_holds", 128'(illegal_seen), 128'(1'b1));
        @(negedge clk);
        check("sticky_holds2", 128'(illegal_seen), 128'(1'b1));
        // Reset with an illegal word present: reset must win.
        reset       = 1'b1;
        instruction = 32'h00000000;
        @(negedge clk);
        check("reset_priority", 128'(illegal_seen), 128'(1'b0));
        reset       = 1'b0;
        instruction = 32'h00000013;
        @(negedge clk);
        check("after_reset_clear", 128'(illegal_seen), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
